exu_bp_upd_q: RTL and testbench

- Branch-predictor update queue directly downstream of the EXU ALU branch-resolution stage.
- Captures each resolved branch (PC, actual direction, mispredict flag, updated 2-bit history, BTB way) in the cycle it resolves.
- Buffers entries in a small FIFO and drains them, one per accepted handshake, to the IFU BTB/BHT write port.
- Decouples ALU resolution timing from predictor write-port availability.

---
 rtl/exu_bp_upd_q_pkg.sv | 16 +
 rtl/exu_bp_upd_ptr.sv | 47 ++++
 rtl/exu_bp_upd_q.sv | 109 ++++++++++
 tb/tb_exu_bp_upd_q.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_bp_upd_q_pkg.sv
// Shared types and defaults for the EXU branch-predictor update queue.
package exu_bp_upd_q_pkg;

    localparam int BP_UPD_DEPTH_DEF = 4;
    localparam int BP_UPD_HISTW_DEF = 2;

    // Canonical field order of a queued update; the top packs entries the same way.
    typedef struct packed {
        logic [31:1]                 pc;
        logic                        ataken;
        logic                        misp;
        logic [BP_UPD_HISTW_DEF-1:0] hist;
        logic                        way;
    } bp_upd_pkt_t;

endpackage

// File: rtl/exu_bp_upd_ptr.sv
// Wrap-bit read/write pointer pair with full/empty flags for a power-of-two FIFO.
module exu_bp_upd_ptr #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        enq,
    input  logic        deq,
    input  logic        clear,
    output logic [AW:0] rd_ptr,
    output logic [AW:0] wr_ptr,
    output logic        full,
    output logic        empty
);

    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0] wr_ptr_reg, wr_ptr_next;

    // Clear snaps the read pointer onto the write pointer; callers gate enq with clear.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (clear)
            rd_ptr_next = wr_ptr_reg;
        else if (deq)
            rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
        if (enq)
            wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    assign rd_ptr = rd_ptr_reg;
    assign wr_ptr = wr_ptr_reg;
    assign empty  = (rd_ptr_reg == wr_ptr_reg);
    assign full   = (rd_ptr_reg[AW-1:0] == wr_ptr_reg[AW-1:0]) && (rd_ptr_reg[AW] != wr_ptr_reg[AW]);

endmodule

// File: rtl/exu_bp_upd_q.sv
// Branch-predictor update FIFO between EXU branch resolution and the IFU BTB/BHT write port.
// Optional statistics counters are built when EXU_BP_UPD_STATS_EN is defined.
module exu_bp_upd_q
    import exu_bp_upd_q_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH_DEF,
    parameter int HISTW = 2,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    input  logic [31:1]      upd_pc,
    input  logic             upd_ataken,
    input  logic             upd_misp,
    input  logic [HISTW-1:0] upd_hist,
    input  logic             upd_way,
    output logic             upd_drop,
    input  logic             freeze,
    input  logic             bp_clear,
    output logic             bp_upd_valid,
    input  logic             bp_upd_ready,
    output logic [31:1]      bp_upd_pc,
    output logic             bp_upd_ataken,
    output logic             bp_upd_misp,
    output logic [HISTW-1:0] bp_upd_hist,
    output logic             bp_upd_way,
    output logic             q_full,
    output logic             q_empty
`ifdef EXU_BP_UPD_STATS_EN
    ,
    output logic [CNTW-1:0]  stat_enq_cnt,
    output logic [CNTW-1:0]  stat_drop_cnt,
    output logic [CNTW-1:0]  stat_misp_cnt
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PKTW = $bits(bp_upd_pkt_t) - BP_UPD_HISTW_DEF + HISTW;

    logic [AW:0]     rd_ptr, wr_ptr;
    logic            full, empty;
    logic            enq, deq;
    logic [PKTW-1:0] wr_pkt, head_pkt;
    logic [PKTW-1:0] mem_reg [DEPTH];

    assign bp_upd_valid = ~empty & ~freeze;
    assign deq          = bp_upd_valid & bp_upd_ready;
    // A clear discards the incoming update outright: neither enqueued nor reported as a drop.
    assign enq          = upd_valid & ~freeze & ~bp_clear & (~full | deq);
    assign upd_drop     = upd_valid & ~freeze & ~bp_clear & full & ~deq;

    exu_bp_upd_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk    (clk),
        .srst   (rst),
        .enq    (enq),
        .deq    (deq),
        .clear  (bp_clear),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .full   (full),
        .empty  (empty)
    );

    assign wr_pkt = {upd_pc, upd_ataken, upd_misp, upd_hist, upd_way};

    // Payload flops carry no reset; validity is tracked by the pointers alone.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (enq && (wr_ptr[AW-1:0] == AW'(gi)))
                mem_reg[gi] <= wr_pkt;
        end
    end

    assign head_pkt      = mem_reg[rd_ptr[AW-1:0]];
    assign bp_upd_pc     = head_pkt[PKTW-1:HISTW+3];
    assign bp_upd_ataken = head_pkt[HISTW+2];
    assign bp_upd_misp   = head_pkt[HISTW+1];
    assign bp_upd_hist   = head_pkt[HISTW:1];
    assign bp_upd_way    = head_pkt[0];

    assign q_full  = full;
    assign q_empty = empty;

`ifdef EXU_BP_UPD_STATS_EN
    logic [CNTW-1:0] stat_enq_reg, stat_drop_reg, stat_misp_reg;

    // Saturating counters: each holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_enq_reg  <= '0;
            stat_drop_reg <= '0;
            stat_misp_reg <= '0;
        end else begin
            if (enq && !(&stat_enq_reg))
                stat_enq_reg <= stat_enq_reg + CNTW'(1);
            if (upd_drop && !(&stat_drop_reg))
                stat_drop_reg <= stat_drop_reg + CNTW'(1);
            if (enq && upd_misp && !(&stat_misp_reg))
                stat_misp_reg <= stat_misp_reg + CNTW'(1);
        end
    end

    assign stat_enq_cnt  = stat_enq_reg;
    assign stat_drop_cnt = stat_drop_reg;
    assign stat_misp_cnt = stat_misp_reg;
`endif

endmodule

// File: tb/tb_exu_bp_upd_q.sv
// Scoreboard bench for exu_bp_upd_q: directed stimulus pushes expected packets, a monitor pops on each handshake.
module tb_exu_bp_upd_q;

    typedef struct packed {
        logic [31:1] pc;
        logic        ataken;
        logic        misp;
        logic [1:0]  hist;
        logic        way;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic [31:1] upd_pc;
    logic        upd_ataken;
    logic        upd_misp;
    logic [1:0]  upd_hist;
    logic        upd_way;
    logic        upd_drop;
    logic        freeze;
    logic        bp_clear;
    logic        bp_upd_valid;
    logic        bp_upd_ready;
    logic [31:1] bp_upd_pc;
    logic        bp_upd_ataken;
    logic        bp_upd_misp;
    logic [1:0]  bp_upd_hist;
    logic        bp_upd_way;
    logic        q_full;
    logic        q_empty;
`ifdef EXU_BP_UPD_STATS_EN
    logic [3:0]  stat_enq_cnt, stat_drop_cnt, stat_misp_cnt;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    pkt_t exp_q[$];

    always #5 clk = ~clk;

`ifdef EXU_BP_UPD_STATS_EN
    exu_bp_upd_q #(.DEPTH(4), .HISTW(2), .CNTW(4)) dut (
`else
    exu_bp_upd_q #(.DEPTH(4), .HISTW(2), .CNTW(16)) dut (
`endif
        .clk           (clk),
        .rst           (rst),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_ataken    (upd_ataken),
        .upd_misp      (upd_misp),
        .upd_hist      (upd_hist),
        .upd_way       (upd_way),
        .upd_drop      (upd_drop),
        .freeze        (freeze),
        .bp_clear      (bp_clear),
        .bp_upd_valid  (bp_upd_valid),
        .bp_upd_ready  (bp_upd_ready),
        .bp_upd_pc     (bp_upd_pc),
        .bp_upd_ataken (bp_upd_ataken),
        .bp_upd_misp   (bp_upd_misp),
        .bp_upd_hist   (bp_upd_hist),
        .bp_upd_way    (bp_upd_way),
        .q_full        (q_full),
        .q_empty       (q_empty)
`ifdef EXU_BP_UPD_STATS_EN
        ,
        .stat_enq_cnt  (stat_enq_cnt),
        .stat_drop_cnt (stat_drop_cnt),
        .stat_misp_cnt (stat_misp_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [31:1] pc, input logic at, input logic mi);
        pkt_t p;
        p.pc     = pc;
        p.ataken = at;
        p.misp   = mi;
        p.hist   = pc[2:1];
        p.way    = pc[3];
        return p;
    endfunction

    // Drive one update onto the inputs; push=1 when the queue is expected to keep it.
    task automatic drive(input logic [31:1] pc, input logic at, input logic mi, input bit push);
        pkt_t p;
        p          = mk(pc, at, mi);
        upd_valid  = 1'b1;
        upd_pc     = p.pc;
        upd_ataken = p.ataken;
        upd_misp   = p.misp;
        upd_hist   = p.hist;
        upd_way    = p.way;
        if (push)
            exp_q.push_back(p);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bp_upd_valid && bp_upd_ready) begin
            pkt_t act, e;
            act = {bp_upd_pc, bp_upd_ataken, bp_upd_misp, bp_upd_hist, bp_upd_way};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_deq: got pc=%0h expected no entry", bp_upd_pc);
            end else begin
                e = exp_q.pop_front();
                $display("deq pc=%0h at=%0b misp=%0b hist=%0d way=%0b", act.pc, act.ataken, act.misp, act.hist, act.way);
                chk("deq_pkt", 64'(act), 64'(e));
            end
        end
    end

    initial begin
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_ataken = 1'b0; upd_misp = 1'b0;
        upd_hist = '0; upd_way = 1'b0; freeze = 1'b0; bp_clear = 1'b0; bp_upd_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("rst_q_empty", 64'(q_empty), 64'd1);
        chk("rst_q_full", 64'(q_full), 64'd0);
        chk("rst_valid", 64'(bp_upd_valid), 64'd0);
        chk("rst_drop", 64'(upd_drop), 64'd0);

        // Single enqueue, visible next cycle, accepted immediately.
        bp_upd_ready = 1'b1;
        drive(31'h800, 1'b1, 1'b0, 1'b1);
        #1 chk("no_bypass_valid", 64'(bp_upd_valid), 64'd0);
        cyc();
        upd_valid = 1'b0;
        #1;
        chk("single_valid", 64'(bp_upd_valid), 64'd1);
        chk("single_pc", 64'(bp_upd_pc), 64'h800);
        cyc();
        #1 chk("single_empty_after", 64'(q_empty), 64'd1);

        // Fill to DEPTH with ready low; fifth update is dropped.
        bp_upd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(31'(i), 1'(i), 1'b0, 1'b1);
            cyc();
        end
        drive(31'd5, 1'b1, 1'b1, 1'b0);
        #1;
        chk("fill_full", 64'(q_full), 64'd1);
        chk("fill_drop", 64'(upd_drop), 64'd1);
        cyc();
        upd_valid = 1'b0;
        #1;
        chk("fill_still_full", 64'(q_full), 64'd1);
        chk("fill_drop_off", 64'(upd_drop), 64'd0);
        bp_upd_ready = 1'b1;
        repeat (4) cyc();
        #1 chk("fill_drained", 64'(q_empty), 64'd1);

        // Full queue with simultaneous enqueue and dequeue.
        bp_upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(31'h10 + 31'(i), 1'b0, 1'(i), 1'b1);
            cyc();
        end
        drive(31'h14, 1'b0, 1'b1, 1'b1);
        bp_upd_ready = 1'b1;
        #1;
        chk("fulldeq_no_drop", 64'(upd_drop), 64'd0);
        chk("fulldeq_full_before", 64'(q_full), 64'd1);
        cyc();
        upd_valid = 1'b0;
        bp_upd_ready = 1'b0;
        #1 chk("fulldeq_still_full", 64'(q_full), 64'd1);
        bp_upd_ready = 1'b1;
        repeat (4) cyc();
        #1 chk("fulldeq_drained", 64'(q_empty), 64'd1);

        // Freeze holds the queue and ignores new updates.
        bp_upd_ready = 1'b0;
        drive(31'h20, 1'b1, 1'b0, 1'b1); cyc();
        drive(31'h21, 1'b0, 1'b1, 1'b1); cyc();
        freeze = 1'b1;
        bp_upd_ready = 1'b1;
        drive(31'h2F, 1'b1, 1'b1, 1'b0);
        #1;
        chk("frz_valid", 64'(bp_upd_valid), 64'd0);
        chk("frz_drop", 64'(upd_drop), 64'd0);
        repeat (2) cyc();
        #1;
        chk("frz_held_nonempty", 64'(q_empty), 64'd0);
        chk("frz_not_full", 64'(q_full), 64'd0);
        freeze = 1'b0;
        upd_valid = 1'b0;
        repeat (2) cyc();
        #1 chk("frz_drained", 64'(q_empty), 64'd1);

        // bp_clear with three entries and a colliding update.
        bp_upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(31'h30 + 31'(i), 1'b1, 1'b0, 1'b0);
            cyc();
        end
        bp_clear = 1'b1;
        drive(31'h3F, 1'b1, 1'b1, 1'b0);
        #1 chk("clr_no_drop", 64'(upd_drop), 64'd0);
        cyc();
        bp_clear = 1'b0;
        upd_valid = 1'b0;
        #1;
        chk("clr_empty", 64'(q_empty), 64'd1);
        chk("clr_valid", 64'(bp_upd_valid), 64'd0);

        // Streaming after clear; ten entries wrap the pointers.
        bp_upd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(31'h40 + 31'(i), 1'(i >> 1), 1'(i), 1'b1);
            cyc();
        end
        upd_valid = 1'b0;
        repeat (2) cyc();
        #1 chk("stream_drained", 64'(q_empty), 64'd1);

        // Reset with entries in flight discards them.
        bp_upd_ready = 1'b0;
        drive(31'h50, 1'b0, 1'b0, 1'b0); cyc();
        drive(31'h51, 1'b0, 1'b0, 1'b0); cyc();
        upd_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(bp_upd_valid), 64'd0);
        chk("midrst_empty", 64'(q_empty), 64'd1);

`ifdef EXU_BP_UPD_STATS_EN
        bp_upd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(31'h60 + 31'(i), 1'b0, 1'b1, 1'b1);
            cyc();
        end
        upd_valid = 1'b0;
        repeat (2) cyc();
        #1;
        chk("stat_enq_sat", 64'(stat_enq_cnt), 64'd15);
        chk("stat_misp_sat", 64'(stat_misp_cnt), 64'd15);
        chk("stat_drop_zero", 64'(stat_drop_cnt), 64'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("stat_enq_rst", 64'(stat_enq_cnt), 64'd0);
        chk("stat_misp_rst", 64'(stat_misp_cnt), 64'd0);
        chk("stat_drop_rst", 64'(stat_drop_cnt), 64'd0);
`endif

        repeat (3) cyc();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
